pipe_stage_skid: RTL

//  Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_sat_counter.sv | 20 ++
 rtl/pipe_stage_skid.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register family.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam int CTRL_W_DEFAULT = 8;

    // EMPTY: nothing held; FULL: main holds a beat; SKID: main and skid both hold a beat.
    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // Increment on enabled edges until the maximum value is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
// Handshake: a beat moves on either side only at a clk edge where valid && ready;
// valid never depends on ready, in_ready is a flop so ready never ripples across
// a stage, and a presented out beat stays stable until it transfers or is flushed.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = CTRL_W_DEFAULT,
    parameter int CNT_W      = 16,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [1:0]        dbg_state
);

    pipe_state_e       state_q, state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              accept, xfer;
    logic              ld_main_in, ld_main_skid, ld_skid, clr;

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid && out_ready;

    // Next-state and register-load decisions; flush overrides everything.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        clr          = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
            clr     = 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d    = S_FULL;
                        ld_main_in = 1'b1;
                    end
                end
                S_FULL: begin
                    if (accept && xfer) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        state_d = S_SKID;
                        ld_skid = 1'b1;
                    end else if (xfer) begin
                        state_d = S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (xfer) begin
                        state_d      = S_FULL;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State register and registered in_ready (low only while the skid is occupied).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_SKID);
        end
    end

    // Main and skid payload registers; ctrl always cleared on flush, data optionally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (clr) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (ld_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (ld_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (ld_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // out_valid comes straight from the state flop so reset drops it asynchronously;
    // ctrl is masked so stale write enables never leak downstream.
    assign out_valid = (state_q != S_EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign in_ready  = in_ready_q;
    assign dbg_state = state_q;

    pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (!out_valid),
        .count (bubble_count)
    );

endmodule
